issue_ctrl: RTL

Issue controller between the decode stage and the execution units. It gates each decoded instruction until its source and destination registers are free in a 32-entry scoreboard, its target execution unit is ready, and the memory unit has a free load slot. It also holds fetch while a jump (JAL/JALR) is unresolved. It consumes the decoder's combinational outputs and produces one-hot issue strobes toward ALU, MEM and forwarder units.

---
 rtl/issue_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: gates decoded instructions on scoreboard hazards, execution-unit
// readiness and load credits. Issues a one-hot strobe to the target unit and
// holds fetch while a jump is unresolved.
module issue_ctrl #(
  parameter int REG_NUM     = 32,
  parameter int REG_W       = 5,
  parameter int EX_UNIT_NUM = 3,
  parameter int EX_W        = 2,
  parameter int MAX_LOADS   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [EX_W-1:0]        dec_ex_unit,
  input  logic [1:0]             dec_rs_ce,
  input  logic [REG_W-1:0]       dec_rs1,
  input  logic [REG_W-1:0]       dec_rs2,
  input  logic                   dec_rd_ce,
  input  logic [REG_W-1:0]       dec_rd,
  input  logic                   dec_stall,
  input  logic                   dec_load_tag,
  input  logic [EX_UNIT_NUM-1:0] ex_ready,
  output logic [EX_UNIT_NUM-1:0] issue_valid,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_rd,
  input  logic                   load_done,
  input  logic                   jump_done,
  output logic                   fetch_hold,
  output logic [REG_NUM-1:0]     busy_vec
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_JUMP_WAIT = 1'b1;

  localparam logic [EX_W-1:0] EX_MEM_UNIT = EX_W'(1);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic [REG_NUM-1:0] eff_busy;
  logic [2:0]         load_cnt;
  logic [2:0]         load_cnt_nxt;

  logic raw, waw, unit_legal, unit_ready, load_block, fire;
  logic is_mem_load, rd_set, load_inc, load_dec;

  // Hazard evaluation against the scoreboard with same-cycle writeback bypass
  always_comb begin
    eff_busy = busy;
    if (wb_valid) eff_busy[wb_rd] = 1'b0;
    raw = (dec_rs_ce[0] & eff_busy[dec_rs1]) | (dec_rs_ce[1] & eff_busy[dec_rs2]);
    waw = dec_rd_ce & (dec_rd != '0) & eff_busy[dec_rd];
  end

  // Issue decision and one-hot strobe; illegal units bypass ex_ready and are just consumed
  always_comb begin
    unit_legal = (32'(dec_ex_unit) < 32'(EX_UNIT_NUM));
    unit_ready = 1'b0;
    for (int unsigned i = 0; i < EX_UNIT_NUM; i++) begin
      if (dec_ex_unit == EX_W'(i)) unit_ready = ex_ready[i];
    end
    is_mem_load = (dec_ex_unit == EX_MEM_UNIT) & dec_load_tag;
    load_block  = is_mem_load & (load_cnt == 3'(MAX_LOADS));
    fire = rst_n & (state == ST_RUN) & if_valid & ~raw & ~waw
         & (unit_ready | ~unit_legal) & ~load_block;
    if_ready    = fire;
    issue_valid = '0;
    for (int unsigned i = 0; i < EX_UNIT_NUM; i++) begin
      if (dec_ex_unit == EX_W'(i)) issue_valid[i] = fire;
    end
    fetch_hold = rst_n & (state == ST_JUMP_WAIT);
    busy_vec   = busy;
  end

  // Next-state for scoreboard, load credits and jump FSM; a set beats a same-register clear
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    rd_set = fire & unit_legal & dec_rd_ce & (dec_rd != '0);
    if (rd_set) busy_nxt[dec_rd] = 1'b1;
    busy_nxt[0] = 1'b0;

    load_inc = fire & is_mem_load;
    load_dec = load_done & (load_cnt != '0);
    load_cnt_nxt = load_cnt;
    if (load_inc & ~load_dec)      load_cnt_nxt = load_cnt + 3'd1;
    else if (~load_inc & load_dec) load_cnt_nxt = load_cnt - 3'd1;

    state_nxt = state;
    case (state)
      ST_RUN:       if (fire & dec_stall) state_nxt = ST_JUMP_WAIT;
      ST_JUMP_WAIT: if (jump_done)        state_nxt = ST_RUN;
      default:                            state_nxt = ST_RUN;
    endcase
  end

  // Registered state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      busy     <= '0;
      load_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= busy_nxt;
      load_cnt <= load_cnt_nxt;
    end
  end

endmodule
